// File: rtl/crypto_op_scheduler.sv
// crypto_op_scheduler
// Shares one SM3/SM4 accelerator between the SM3 and SM4 instruction streams:
// round-robin arbitration, SM4 key-pull phase, message word streaming into the
// selected engine, completion wait and pipeline stall.
// Build option: define CRYPTO_SCHED_TIMEOUT_EN to add a watchdog in the WAIT
// states that aborts to IDLE with a timeout_o pulse after TIMEOUT_CYCLES cycles.
module crypto_op_scheduler #(
   parameter int KEY_CYCLES     = 4,
   parameter int SM4_WORDS      = 4,
   parameter int SM3_MAX_WORDS  = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        gated_clk,
   input  logic        RST,
   input  logic        sm3_req_i,
   input  logic        sm4_req_i,
   output logic        sm3_gnt_o,
   output logic        sm4_gnt_o,
   input  logic        msg_valid_i,
   input  logic [31:0] msg_i,
   input  logic        sm3_last_i,
   output logic        msg_ready_o,
   output logic [31:0] message_o,
   output logic        valid_in_sm3_o,
   output logic        valid_in_sm4_o,
   output logic        m_sm3_o,
   output logic        pull_key_en_o,
   input  logic        hold_pipeline_sm3_i,
   input  logic        hold_pipeline_sm4_i,
   input  logic        out_of_loop_i,
   output logic        stall_o,
   output logic        done_o,
   output logic        timeout_o
);

   localparam int MAX_WORDS = (SM3_MAX_WORDS > SM4_WORDS) ? SM3_MAX_WORDS : SM4_WORDS;
   localparam int CNT_W     = $clog2(MAX_WORDS) + 1;
   localparam int KEY_W     = $clog2(KEY_CYCLES) + 1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_KEY      = 3'd1,
      ST_SM4_FEED = 3'd2,
      ST_SM4_WAIT = 3'd3,
      ST_SM3_FEED = 3'd4,
      ST_SM3_WAIT = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [KEY_W-1:0]   key_cnt_r;
   logic               wait_armed_r;
   logic               rr_r;
   logic               sm3_gnt_r;
   logic               sm4_gnt_r;
   logic               msg_ready_r;
   logic [31:0]        message_r;
   logic               valid_sm3_r;
   logic               valid_sm4_r;
   logic               m_sm3_r;
   logic               pull_key_r;
   logic               done_r;
   logic               timeout_r;

   logic               feed_s;
   logic               accept_s;
   logic               sm3_final_s;
   logic               gnt_sm3_s;
   logic               gnt_sm4_s;
   logic               timeout_hit_s;
   logic               unused_s;

   // SM4 busy is informational only; SM4 completion comes from out_of_loop_i.
   assign unused_s    = hold_pipeline_sm4_i & (TIMEOUT_CYCLES > 0);

   assign feed_s      = (state_r == ST_SM3_FEED) | (state_r == ST_SM4_FEED);
   assign accept_s    = msg_valid_i & feed_s;
   // The last SM3 word is either flagged by the requester or forced at the word limit.
   assign sm3_final_s = sm3_last_i | (cnt_r == CNT_W'(SM3_MAX_WORDS - 1));
   // Contested requests go to the pointer's side; rr_r = 0 favours SM3.
   assign gnt_sm3_s   = (state_r == ST_IDLE) & sm3_req_i & (~sm4_req_i | ~rr_r);
   assign gnt_sm4_s   = (state_r == ST_IDLE) & sm4_req_i & (~sm3_req_i |  rr_r);

`ifdef CRYPTO_SCHED_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt_r;
   logic             wait_s;

   assign wait_s        = (state_r == ST_SM3_WAIT) | (state_r == ST_SM4_WAIT);
   assign timeout_hit_s = wait_s & (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: counts cycles spent in a WAIT state, restarting on every entry.
   always_ff @(posedge gated_clk or negedge RST) begin
      if (!RST) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (wait_s && (state_s == state_r)) begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end else begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end
   end
`else
   assign timeout_hit_s = 1'b0;
`endif

   // Next-state logic; completion takes priority over a simultaneous watchdog expiry.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (gnt_sm3_s) state_s = ST_SM3_FEED;
            else if (gnt_sm4_s) state_s = ST_KEY;
            else state_s = ST_IDLE;
         end
         ST_KEY: begin
            if (key_cnt_r == KEY_W'(KEY_CYCLES - 1)) state_s = ST_SM4_FEED;
            else state_s = ST_KEY;
         end
         ST_SM4_FEED: begin
            if (accept_s && (cnt_r == CNT_W'(SM4_WORDS - 1))) state_s = ST_SM4_WAIT;
            else state_s = ST_SM4_FEED;
         end
         ST_SM4_WAIT: begin
            if (out_of_loop_i) state_s = ST_DONE;
            else if (timeout_hit_s) state_s = ST_IDLE;
            else state_s = ST_SM4_WAIT;
         end
         ST_SM3_FEED: begin
            if (accept_s && sm3_final_s) state_s = ST_SM3_WAIT;
            else state_s = ST_SM3_FEED;
         end
         ST_SM3_WAIT: begin
            // The engine cannot raise its busy flag in the first WAIT cycle, so ignore it there.
            if (wait_armed_r && !hold_pipeline_sm3_i) state_s = ST_DONE;
            else if (timeout_hit_s) state_s = ST_IDLE;
            else state_s = ST_SM3_WAIT;
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge gated_clk or negedge RST) begin
      if (!RST) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Word and key-cycle counters, cleared on every state change; wait_armed_r marks WAIT cycle 2+.
   always_ff @(posedge gated_clk or negedge RST) begin
      if (!RST) begin
         cnt_r        <= {CNT_W{1'b0}};
         key_cnt_r    <= {KEY_W{1'b0}};
         wait_armed_r <= 1'b0;
      end else begin
         wait_armed_r <= (state_r == ST_SM3_WAIT);
         if (state_s != state_r) begin
            cnt_r     <= {CNT_W{1'b0}};
            key_cnt_r <= {KEY_W{1'b0}};
         end else begin
            if (accept_s) cnt_r <= cnt_r + CNT_W'(1);
            if (state_r == ST_KEY) key_cnt_r <= key_cnt_r + KEY_W'(1);
         end
      end
   end

   // Registered outputs derived from the next state and the accepted word, plus the round-robin pointer.
   always_ff @(posedge gated_clk or negedge RST) begin
      if (!RST) begin
         rr_r        <= 1'b0;
         sm3_gnt_r   <= 1'b0;
         sm4_gnt_r   <= 1'b0;
         msg_ready_r <= 1'b0;
         message_r   <= 32'h0000_0000;
         valid_sm3_r <= 1'b0;
         valid_sm4_r <= 1'b0;
         m_sm3_r     <= 1'b0;
         pull_key_r  <= 1'b0;
         done_r      <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         if (gnt_sm3_s || gnt_sm4_s) rr_r <= ~rr_r;
         sm3_gnt_r   <= gnt_sm3_s;
         sm4_gnt_r   <= gnt_sm4_s;
         msg_ready_r <= (state_s == ST_SM3_FEED) | (state_s == ST_SM4_FEED);
         if (accept_s) message_r <= msg_i;
         valid_sm3_r <= accept_s & (state_r == ST_SM3_FEED);
         valid_sm4_r <= accept_s & (state_r == ST_SM4_FEED);
         m_sm3_r     <= accept_s & (state_r == ST_SM3_FEED) & sm3_final_s;
         pull_key_r  <= (state_s == ST_KEY);
         done_r      <= (state_s == ST_DONE);
         timeout_r   <= timeout_hit_s & (state_s == ST_IDLE);
      end
   end

   assign sm3_gnt_o      = sm3_gnt_r;
   assign sm4_gnt_o      = sm4_gnt_r;
   assign msg_ready_o    = msg_ready_r;
   assign message_o      = message_r;
   assign valid_in_sm3_o = valid_sm3_r;
   assign valid_in_sm4_o = valid_sm4_r;
   assign m_sm3_o        = m_sm3_r;
   assign pull_key_en_o  = pull_key_r;
   assign done_o         = done_r;
   assign timeout_o      = timeout_r;
   assign stall_o        = (state_r != ST_IDLE) | sm3_req_i | sm4_req_i;

endmodule

// File: tb/tb_crypto_op_scheduler.sv
// Directed self-checking bench for crypto_op_scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_crypto_op_scheduler;

   logic        gated_clk = 1'b0;
   logic        RST = 1'b0;
   logic        sm3_req_i = 1'b0;
   logic        sm4_req_i = 1'b0;
   logic        msg_valid_i = 1'b0;
   logic [31:0] msg_i = 32'h0;
   logic        sm3_last_i = 1'b0;
   logic        hold_pipeline_sm3_i = 1'b0;
   logic        hold_pipeline_sm4_i = 1'b0;
   logic        out_of_loop_i = 1'b0;
   logic        sm3_gnt_o, sm4_gnt_o, msg_ready_o, valid_in_sm3_o, valid_in_sm4_o;
   logic        m_sm3_o, pull_key_en_o, stall_o, done_o, timeout_o;
   logic [31:0] message_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 gated_clk = ~gated_clk;

   crypto_op_scheduler dut (
      .gated_clk(gated_clk), .RST(RST),
      .sm3_req_i(sm3_req_i), .sm4_req_i(sm4_req_i),
      .sm3_gnt_o(sm3_gnt_o), .sm4_gnt_o(sm4_gnt_o),
      .msg_valid_i(msg_valid_i), .msg_i(msg_i), .sm3_last_i(sm3_last_i),
      .msg_ready_o(msg_ready_o), .message_o(message_o),
      .valid_in_sm3_o(valid_in_sm3_o), .valid_in_sm4_o(valid_in_sm4_o),
      .m_sm3_o(m_sm3_o), .pull_key_en_o(pull_key_en_o),
      .hold_pipeline_sm3_i(hold_pipeline_sm3_i), .hold_pipeline_sm4_i(hold_pipeline_sm4_i),
      .out_of_loop_i(out_of_loop_i), .stall_o(stall_o), .done_o(done_o), .timeout_o(timeout_o)
   );

   task automatic tick();
      @(negedge gated_clk);
   endtask

   // Streams n words base, base+1, ... whenever msg_ready_o is high; checks each word one cycle later.
   task automatic feed(input logic is_sm3, input int n, input logic use_last, input logic gaps,
                       input logic [31:0] base);
      logic        exp_v = 1'b0;
      logic [31:0] exp_w = 32'h0;
      logic        exp_m = 1'b0;
      int          sent = 0;
      bit          fin = 1'b0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         if (msg_ready_o === 1'b1 && sent < n && !(gaps && (cyc % 2 == 1))) begin
            msg_valid_i = 1'b1;
            msg_i       = base + 32'(sent);
            sm3_last_i  = use_last && (sent == n - 1);
            exp_v = 1'b1;
            exp_w = base + 32'(sent);
            exp_m = is_sm3 && ((use_last && (sent == n - 1)) || (sent == 15));
            sent++;
         end else begin
            msg_valid_i = 1'b0;
            sm3_last_i  = 1'b0;
            exp_v       = 1'b0;
         end
         tick();
         n_checks++;
         if (exp_v) begin
            if ((is_sm3 ? valid_in_sm3_o : valid_in_sm4_o) !== 1'b1 ||
                (is_sm3 ? valid_in_sm4_o : valid_in_sm3_o) !== 1'b0 ||
                message_o !== exp_w || m_sm3_o !== exp_m) begin
               n_fail++;
               $display("FAIL feed_word[%0d]: got v3=%b v4=%b msg=%h m_sm3=%b, expected sm3_path=%b msg=%h m_sm3=%b",
                        sent - 1, valid_in_sm3_o, valid_in_sm4_o, message_o, m_sm3_o, is_sm3, exp_w, exp_m);
            end
         end else if (valid_in_sm3_o !== 1'b0 || valid_in_sm4_o !== 1'b0 || m_sm3_o !== 1'b0) begin
            n_fail++;
            $display("FAIL feed_idle: got v3=%b v4=%b m_sm3=%b, expected 0 0 0",
                     valid_in_sm3_o, valid_in_sm4_o, m_sm3_o);
         end
         n_checks++;
         if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL feed_stall: got %b, expected 1", stall_o);
         end
         if (exp_v && sent == n) fin = 1'b1;
      end
      msg_valid_i = 1'b0;
      sm3_last_i  = 1'b0;
      n_checks++;
      if (!fin) begin
         n_fail++;
         $display("FAIL feed_timeout: sent %0d words, expected %0d", sent, n);
      end
   endtask

   // Waits for done_o; it must appear exactly exp_n falling edges from now and last one cycle.
   task automatic wait_done(input int exp_n);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < exp_n + 8) begin
         tick();
         n++;
         if (done_o === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen || n != exp_n) begin
         n_fail++;
         $display("FAIL done_latency: got done after %0d cycles (seen=%b), expected %0d", n, seen, exp_n);
      end
      tick();
      n_checks++;
      if (done_o !== 1'b0 || timeout_o !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: got done=%b timeout=%b, expected 0 0", done_o, timeout_o);
      end
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({sm3_gnt_o, sm4_gnt_o, msg_ready_o, valid_in_sm3_o, valid_in_sm4_o, m_sm3_o,
           pull_key_en_o, stall_o, done_o, timeout_o} !== 10'b0 || message_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got flags=%b msg=%h, expected all 0",
                  {sm3_gnt_o, sm4_gnt_o, msg_ready_o, valid_in_sm3_o, valid_in_sm4_o, m_sm3_o,
                   pull_key_en_o, stall_o, done_o, timeout_o}, message_o);
      end
      RST = 1'b1;
      tick();
      n_checks++;
      if (stall_o !== 1'b0 || msg_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got stall=%b ready=%b, expected 0 0", stall_o, msg_ready_o);
      end
      sm3_req_i = 1'b1;
      #1;
      n_checks++;
      if (stall_o !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_on_req: got %b, expected 1", stall_o);
      end
      tick();
      n_checks++;
      if (sm3_gnt_o !== 1'b1 || sm4_gnt_o !== 1'b0 || msg_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL first_sm3_gnt: got gnt3=%b gnt4=%b ready=%b, expected 1 0 1",
                  sm3_gnt_o, sm4_gnt_o, msg_ready_o);
      end
      sm3_req_i = 1'b0;
      feed(1'b1, 1, 1'b1, 1'b0, 32'h3000_0001);
      // Busy flag stays low: earliest exit is the second WAIT cycle.
      wait_done(2);
      n_checks++;
      if (stall_o !== 1'b0 || msg_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_sm3: got stall=%b ready=%b, expected 0 0", stall_o, msg_ready_o);
      end
   endtask

   task automatic test_sm4_op();
      sm4_req_i = 1'b1;
      tick();
      n_checks++;
      if (sm4_gnt_o !== 1'b1 || sm3_gnt_o !== 1'b0 || pull_key_en_o !== 1'b1 || stall_o !== 1'b1) begin
         n_fail++;
         $display("FAIL sm4_gnt: got gnt4=%b gnt3=%b pull=%b stall=%b, expected 1 0 1 1",
                  sm4_gnt_o, sm3_gnt_o, pull_key_en_o, stall_o);
      end
      sm4_req_i = 1'b0;
      // A word offered during the key pull must be ignored.
      msg_valid_i = 1'b1;
      msg_i       = 32'hDEAD_BEEF;
      for (int k = 1; k < 4; k++) begin
         tick();
         n_checks++;
         if (pull_key_en_o !== 1'b1 || msg_ready_o !== 1'b0 || valid_in_sm4_o !== 1'b0) begin
            n_fail++;
            $display("FAIL key_phase[%0d]: got pull=%b ready=%b v4=%b, expected 1 0 0",
                     k, pull_key_en_o, msg_ready_o, valid_in_sm4_o);
         end
      end
      tick();
      n_checks++;
      if (pull_key_en_o !== 1'b0 || msg_ready_o !== 1'b1 || valid_in_sm4_o !== 1'b0) begin
         n_fail++;
         $display("FAIL key_end: got pull=%b ready=%b v4=%b, expected 0 1 0",
                  pull_key_en_o, msg_ready_o, valid_in_sm4_o);
      end
      feed(1'b0, 4, 1'b0, 1'b0, 32'h0000_00A0);
      hold_pipeline_sm4_i = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         n_checks++;
         if (stall_o !== 1'b1 || done_o !== 1'b0 || msg_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sm4_wait[%0d]: got stall=%b done=%b ready=%b, expected 1 0 0",
                     k, stall_o, done_o, msg_ready_o);
         end
      end
      out_of_loop_i = 1'b1;
      wait_done(1);
      out_of_loop_i       = 1'b0;
      hold_pipeline_sm4_i = 1'b0;
      n_checks++;
      if (stall_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_sm4: got stall=%b, expected 0", stall_o);
      end
   endtask

   task automatic test_sm3_hold();
      sm3_req_i = 1'b1;
      tick();
      n_checks++;
      if (sm3_gnt_o !== 1'b1) begin
         n_fail++;
         $display("FAIL sm3_gnt: got %b, expected 1", sm3_gnt_o);
      end
      sm3_req_i = 1'b0;
      feed(1'b1, 3, 1'b1, 1'b1, 32'h3300_0000);
      n_checks++;
      if (msg_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL sm3_last_exit: got ready=%b, expected 0", msg_ready_o);
      end
      hold_pipeline_sm3_i = 1'b1;
      for (int k = 0; k < 64; k++) begin
         tick();
         n_checks++;
         if (done_o !== 1'b0 || stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sm3_hold[%0d]: got done=%b stall=%b, expected 0 1", k, done_o, stall_o);
         end
      end
      hold_pipeline_sm3_i = 1'b0;
      wait_done(1);
   endtask

   task automatic test_back_to_back_rr();
      RST = 1'b0;
      tick();
      RST = 1'b1;
      tick();
      sm3_req_i = 1'b1;
      sm4_req_i = 1'b1;
      tick();
      n_checks++;
      if (sm3_gnt_o !== 1'b1 || sm4_gnt_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_first: got gnt3=%b gnt4=%b, expected 1 0", sm3_gnt_o, sm4_gnt_o);
      end
      sm3_req_i = 1'b0;
      feed(1'b1, 1, 1'b1, 1'b0, 32'h4400_0000);
      sm3_req_i = 1'b1;
      wait_done(2);
      n_checks++;
      if (sm3_gnt_o !== 1'b0 || sm4_gnt_o !== 1'b0 || stall_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rr_idle: got gnt3=%b gnt4=%b stall=%b, expected 0 0 1", sm3_gnt_o, sm4_gnt_o, stall_o);
      end
      tick();
      n_checks++;
      if (sm4_gnt_o !== 1'b1 || sm3_gnt_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_second: got gnt3=%b gnt4=%b, expected 0 1", sm3_gnt_o, sm4_gnt_o);
      end
      sm4_req_i = 1'b0;
      feed(1'b0, 4, 1'b0, 1'b0, 32'h5500_0000);
      out_of_loop_i = 1'b1;
      wait_done(1);
      out_of_loop_i = 1'b0;
      tick();
      n_checks++;
      if (sm3_gnt_o !== 1'b1 || sm4_gnt_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_pending: got gnt3=%b gnt4=%b, expected 1 0", sm3_gnt_o, sm4_gnt_o);
      end
      sm3_req_i = 1'b0;
      feed(1'b1, 1, 1'b1, 1'b0, 32'h6600_0000);
      wait_done(2);
   endtask

   task automatic test_sm3_max_words();
      sm3_req_i = 1'b1;
      tick();
      sm3_req_i = 1'b0;
      feed(1'b1, 16, 1'b0, 1'b0, 32'h1600_0000);
      n_checks++;
      if (msg_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL max_exit: got ready=%b, expected 0", msg_ready_o);
      end
      msg_valid_i = 1'b1;
      msg_i       = 32'hBAD0_0017;
      sm3_last_i  = 1'b1;
      tick();
      msg_valid_i = 1'b0;
      sm3_last_i  = 1'b0;
      n_checks++;
      if (valid_in_sm3_o !== 1'b0 || m_sm3_o !== 1'b0) begin
         n_fail++;
         $display("FAIL word_after_max: got v3=%b m_sm3=%b, expected 0 0", valid_in_sm3_o, m_sm3_o);
      end
      wait_done(1);
   endtask

   task automatic test_reset_mid_feed();
      sm3_req_i = 1'b1;
      tick();
      sm3_req_i = 1'b0;
      feed(1'b1, 2, 1'b0, 1'b0, 32'h7700_0000);
      msg_valid_i = 1'b1;
      RST = 1'b0;
      #1;
      n_checks++;
      if ({sm3_gnt_o, sm4_gnt_o, msg_ready_o, valid_in_sm3_o, valid_in_sm4_o, m_sm3_o,
           pull_key_en_o, stall_o, done_o, timeout_o} !== 10'b0 || message_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_feed: got flags=%b msg=%h, expected all 0",
                  {sm3_gnt_o, sm4_gnt_o, msg_ready_o, valid_in_sm3_o, valid_in_sm4_o, m_sm3_o,
                   pull_key_en_o, stall_o, done_o, timeout_o}, message_o);
      end
      tick();
      RST = 1'b1;
      msg_valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (sm3_gnt_o !== 1'b0 || msg_ready_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL no_reissue[%0d]: got gnt3=%b ready=%b stall=%b done=%b, expected 0 0 0 0",
                     k, sm3_gnt_o, msg_ready_o, stall_o, done_o);
         end
      end
   endtask

`ifdef CRYPTO_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int n = 0;
      bit seen = 1'b0;
      bit saw_done = 1'b0;
      sm4_req_i = 1'b1;
      tick();
      sm4_req_i = 1'b0;
      feed(1'b0, 4, 1'b0, 1'b0, 32'h8800_0000);
      while (!seen && n < 300) begin
         tick();
         n++;
         if (done_o === 1'b1) saw_done = 1'b1;
         if (timeout_o === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen || n != 255 || saw_done) begin
         n_fail++;
         $display("FAIL timeout_latency: got timeout after %0d cycles (seen=%b done=%b), expected 255 no done",
                  n, seen, saw_done);
      end
      tick();
      n_checks++;
      if (timeout_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_idle: got timeout=%b stall=%b done=%b, expected 0 0 0",
                  timeout_o, stall_o, done_o);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_sm4_op();
      test_sm3_hold();
      test_back_to_back_rr();
      test_sm3_max_words();
`ifdef CRYPTO_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_feed();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
